// File: rtl/vga_sync_scaler.sv
`timescale 1ns/1ps
// vga_sync_scaler: 640x480@60 VGA timing generator with a 2^SCALE_SHIFT upscaled frame-buffer fetch.
// Optional feature macro: VGA_SYNC_BORDER_EN (1-pixel white border on the active area).
module vga_sync_scaler #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int SCALE_SHIFT = 3,
  parameter int ADDR_W      = 13
) (
  input  logic              clk25,
  input  logic              rst_n,
  input  logic [9:0]        sx,
  input  logic [9:0]        sy,
  input  logic [7:0]        pixel_data,
  output logic [ADDR_W-1:0] pixel_addr,
  output logic [2:0]        red,
  output logic [2:0]        green,
  output logic [1:0]        blue,
  output logic              Hsync,
  output logic              Vsync,
  output logic              de,
  output logic              frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT      = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT      = 10'(V_ACTIVE);
  localparam logic [9:0] H_ACT_LAST = 10'(H_ACTIVE - 1);
  localparam logic [9:0] V_ACT_LAST = 10'(V_ACTIVE - 1);
  localparam logic [9:0] HS_BEG     = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_BEG     = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [9:0] SCALE_MASK = 10'((1 << SCALE_SHIFT) - 1);
  localparam logic [ADDR_W-1:0] IMG_W = ADDR_W'(H_ACTIVE >> SCALE_SHIFT);

  logic [9:0]        h, v, v_inc;
  logic [ADDR_W-1:0] row_base, col_off;
  logic              active0, inwin0, hs0, vs0, first0;
  logic              active1, inwin1, hs1, vs1, first1;
  logic [7:0]        rgb_next;
`ifdef VGA_SYNC_BORDER_EN
  logic              border0, border1;
`endif

  // Stage 0: decode the raw counters.
  always_comb begin
    v_inc   = v + 10'd1;
    col_off = ADDR_W'(h >> SCALE_SHIFT);
    active0 = (h < H_ACT) && (v < V_ACT);
    inwin0  = active0 && (h < sx) && (v < sy);
    hs0     = !((h >= HS_BEG) && (h <= HS_END));
    vs0     = !((v >= VS_BEG) && (v <= VS_END));
    first0  = (h == '0) && (v == '0);
  end

`ifdef VGA_SYNC_BORDER_EN
  always_comb begin
    border0 = active0 && ((h == '0) || (h == H_ACT_LAST) || (v == '0) || (v == V_ACT_LAST));
  end
`endif

  // row_base tracks (v >> SCALE_SHIFT) * image width incrementally, stepping
  // when the line about to start begins a new image row.
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      h        <= '0;
      v        <= '0;
      row_base <= '0;
    end else if (h == H_LAST) begin
      h <= '0;
      if (v == V_LAST) begin
        v        <= '0;
        row_base <= '0;
      end else begin
        v <= v_inc;
        if ((v_inc & SCALE_MASK) == '0)
          row_base <= row_base + IMG_W;
      end
    end else begin
      h <= h + 10'd1;
    end
  end

  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      pixel_addr <= '0;
      active1    <= 1'b0;
      inwin1     <= 1'b0;
      hs1        <= 1'b1;
      vs1        <= 1'b1;
      first1     <= 1'b0;
    end else begin
      if (inwin0)
        pixel_addr <= row_base + col_off;
      active1 <= active0;
      inwin1  <= inwin0;
      hs1     <= hs0;
      vs1     <= vs0;
      first1  <= first0;
    end
  end

`ifdef VGA_SYNC_BORDER_EN
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n)
      border1 <= 1'b0;
    else
      border1 <= border0;
  end
`endif

  always_comb begin
    rgb_next = inwin1 ? pixel_data : '0;
`ifdef VGA_SYNC_BORDER_EN
    if (border1)
      rgb_next = '1;
`endif
  end

  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      red         <= '0;
      green       <= '0;
      blue        <= '0;
      Hsync       <= 1'b1;
      Vsync       <= 1'b1;
      de          <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      {red, green, blue} <= rgb_next;
      Hsync       <= hs1;
      Vsync       <= vs1;
      de          <= active1;
      frame_start <= first1;
    end
  end

endmodule
